biquad_seq: RTL and testbench

BIQUAD_SEQ -- requirements
Module: biquad_seq

---
 rtl/biquad_seq.sv | 150 +++++++++++++++
 tb/tb_biquad_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_seq.sv
// Cascaded biquad filter: NSEC second-order sections evaluated on one
// time-shared multiplier, one product per clock, with a writable
// coefficient bank and per-section delay lines.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a sample; coefficient writes and clr_state allowed
// MAC   | one tap product per edge, section by section, until y_out is set
module biquad_seq #(
  parameter  int N     = 24,
  parameter  int F     = 14,
  parameter  int NSEC  = 2,
  localparam int NCOEF = 5 * NSEC,
  localparam int AW    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [N-1:0] x_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [N-1:0] y_out,
  output logic                out_valid,
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic signed [N-1:0] coef_data,
  output logic                coef_err,
  input  logic                clr_state
);

  localparam int SW   = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int ACCW = N + 4;
  localparam logic signed [ACCW-1:0] SMAX = {{5{1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{5{1'b1}}, {(N-1){1'b0}}};
  localparam int ONE_I = 1 << F;
  localparam logic signed [N-1:0] ONE = N'(ONE_I);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                 state;
  logic [SW-1:0]          sec;
  logic [2:0]             tap;
  logic signed [ACCW-1:0] acc;
  logic signed [N-1:0]    xcur;
  logic signed [N-1:0]    coef [NCOEF];
  logic signed [N-1:0]    x1 [NSEC];
  logic signed [N-1:0]    x2 [NSEC];
  logic signed [N-1:0]    y1 [NSEC];
  logic signed [N-1:0]    y2 [NSEC];

  logic [AW-1:0]          cidx;
  logic signed [N-1:0]    csel;
  logic signed [N-1:0]    opnd;
  logic signed [2*N-1:0]  prod;
  logic signed [ACCW-1:0] sum;
  logic signed [N-1:0]    ysat;

  // Datapath: select coefficient/operand for the current tap, multiply,
  // scale back to Q.F, accumulate, and saturate the running section sum.
  always_comb begin
    cidx = AW'(int'(sec) * 5 + int'(tap));
    csel = coef[cidx];
    unique case (tap)
      3'd0:    opnd = xcur;
      3'd1:    opnd = x1[sec];
      3'd2:    opnd = x2[sec];
      3'd3:    opnd = y1[sec];
      default: opnd = y2[sec];
    endcase
    prod = csel * opnd;
    sum  = acc + ACCW'(prod >>> F);
    if (sum > SMAX)      ysat = SMAX[N-1:0];
    else if (sum < SMIN) ysat = SMIN[N-1:0];
    else                 ysat = sum[N-1:0];
  end

  // Sequencer, coefficient bank and delay lines; outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      sec       <= '0;
      tap       <= '0;
      acc       <= '0;
      xcur      <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      for (int i = 0; i < NCOEF; i++) coef[i] <= (i % 5 == 0) ? ONE : '0;
      for (int s = 0; s < NSEC; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      // Writes land only while idle so a sample never sees a mixed bank.
      if (coef_we) begin
        if (state == IDLE && int'(coef_addr) < NCOEF) coef[coef_addr] <= coef_data;
        else coef_err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (clr_state) begin
            for (int s = 0; s < NSEC; s++) begin
              x1[s] <= '0;
              x2[s] <= '0;
              y1[s] <= '0;
              y2[s] <= '0;
            end
          end
          if (in_valid && in_ready) begin
            state    <= MAC;
            in_ready <= 1'b0;
            xcur     <= x_in;
            sec      <= '0;
            tap      <= '0;
            acc      <= '0;
          end
        end
        MAC: begin
          if (tap == 3'd4) begin
            x2[sec] <= x1[sec];
            x1[sec] <= xcur;
            y2[sec] <= y1[sec];
            y1[sec] <= ysat;
            xcur    <= ysat;
            acc     <= '0;
            tap     <= '0;
            if (sec == SW'(NSEC - 1)) begin
              y_out     <= ysat;
              out_valid <= 1'b1;
              state     <= IDLE;
              in_ready  <= 1'b1;
              sec       <= '0;
            end else begin
              sec <= sec + 1'b1;
            end
          end else begin
            acc <= sum;
            tap <= tap + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_seq.sv
// Self-checking bench for biquad_seq: directed scenarios plus randomized
// samples and coefficients compared against a sample-level reference model.
module tb_biquad_seq;
  localparam int N     = 24;
  localparam int F     = 14;
  localparam int NSEC  = 2;
  localparam int NCOEF = 10;
  localparam int AW    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [N-1:0] x_in;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] y_out;
  logic                out_valid;
  logic                coef_we;
  logic [AW-1:0]       coef_addr;
  logic signed [N-1:0] coef_data;
  logic                coef_err;
  logic                clr_state;

  int vectors     = 0;
  int miscompares = 0;

  longint mc  [NCOEF];
  longint mx1 [NSEC];
  longint mx2 [NSEC];
  longint my1 [NSEC];
  longint my2 [NSEC];

  biquad_seq #(.N(N), .F(F), .NSEC(NSEC)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid),
    .in_ready(in_ready), .y_out(y_out), .out_valid(out_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err), .clr_state(clr_state)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (whole samples, plain arithmetic)
  function automatic longint sat(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  // accumulator is N+4 = 28 bits wide: reduce modulo 2^28, signed
  function automatic longint wrap28(input longint v);
    longint t;
    t = v <<< 36;
    return t >>> 36;
  endfunction

  function automatic longint model_step(input longint x);
    longint v, acc, y;
    v = x;
    for (int s = 0; s < NSEC; s++) begin
      acc = ((mc[5*s]   * v)      >>> F) + ((mc[5*s+1] * mx1[s]) >>> F)
          + ((mc[5*s+2] * mx2[s]) >>> F) + ((mc[5*s+3] * my1[s]) >>> F)
          + ((mc[5*s+4] * my2[s]) >>> F);
      y = sat(wrap28(acc));
      mx2[s] = mx1[s];
      mx1[s] = v;
      my2[s] = my1[s];
      my1[s] = y;
      v = y;
    end
    return v;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NSEC; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCOEF; i++) mc[i] = (i % 5 == 0) ? 16384 : 0;
    model_clear();
  endfunction

  // ---------------- stimulus tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0; clr_state = 1'b0;
    x_in = '0; coef_addr = '0; coef_data = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic wr(input int a, input longint d);
    coef_addr = AW'(a);
    coef_data = N'(d);
    coef_we   = 1'b1;
    tick();
    coef_we = 1'b0;
    if (a < NCOEF) mc[a] = d;
  endtask

  task automatic clr();
    clr_state = 1'b1;
    tick();
    clr_state = 1'b0;
    model_clear();
  endtask

  // returns y_out at the out_valid pulse and edges from accept to pulse (-1 on timeout)
  task automatic send(input longint x, output longint y, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin tick(); w++; end
    x_in = N'(x);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = -1;
    y = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin
        y = y_out;
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    do_reset();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (y_out !== '0) begin miscompares++; $display("FAIL reset_y_out got %0d want 0", y_out); end
    vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL reset_coef_err got %b want 0", coef_err); end
  endtask

  task automatic test_passthrough();
    longint y; int lat;
    do_reset();
    send(1000, y, lat);
    vectors++; if (lat != 10) begin miscompares++; $display("FAIL pass_latency got %0d want 10", lat); end
    vectors++; if (y != 1000) begin miscompares++; $display("FAIL pass_y got %0d want 1000", y); end
  endtask

  task automatic test_gain();
    longint y; int lat;
    do_reset();
    wr(0, 8192);
    vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL gain_write_err got %b want 0", coef_err); end
    send(16384, y, lat);
    vectors++; if (y != 8192) begin miscompares++; $display("FAIL gain_pos got %0d want 8192", y); end
    send(-16384, y, lat);
    vectors++; if (y != -8192) begin miscompares++; $display("FAIL gain_neg got %0d want -8192", y); end
  endtask

  task automatic test_integrator();
    longint y; int lat;
    longint xs [3] = '{100, 0, 0};
    do_reset();
    wr(0, 16384);
    wr(3, 16384);
    foreach (xs[i]) begin
      send(xs[i], y, lat);
      vectors++; if (y != 100) begin miscompares++; $display("FAIL integ_%0d got %0d want 100", i, y); end
    end
    clr();
    send(0, y, lat);
    vectors++; if (y != 0) begin miscompares++; $display("FAIL integ_clear got %0d want 0", y); end
  endtask

  task automatic test_saturation();
    longint y; int lat;
    do_reset();
    wr(0, 32768);
    send(8388607, y, lat);
    vectors++; if (y != 8388607) begin miscompares++; $display("FAIL sat_pos got %0d want 8388607", y); end
    send(-8388608, y, lat);
    vectors++; if (y != -8388608) begin miscompares++; $display("FAIL sat_neg got %0d want -8388608", y); end
  endtask

  task automatic test_coef_err();
    longint y; int lat;
    do_reset();
    x_in = N'(777);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
    tick();
    coef_addr = '0; coef_data = N'(999); coef_we = 1'b1;
    tick();
    coef_we = 1'b0;
    vectors++; if (coef_err !== 1'b1) begin miscompares++; $display("FAIL err_busy got %b want 1", coef_err); end
    tick();
    vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL err_busy_width got %b want 0", coef_err); end
    lat = -1; y = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin y = y_out; lat = k; break; end
      tick();
    end
    vectors++; if (lat < 0 || y != 777) begin miscompares++; $display("FAIL err_busy_sample got %0d (found %0d) want 777", y, lat); end
    wr(12, 5);
    vectors++; if (coef_err !== 1'b1) begin miscompares++; $display("FAIL err_addr got %b want 1", coef_err); end
    tick();
    vectors++; if (coef_err !== 1'b0) begin miscompares++; $display("FAIL err_addr_width got %b want 0", coef_err); end
    send(-4242, y, lat);
    vectors++; if (y != -4242) begin miscompares++; $display("FAIL err_after got %0d want -4242", y); end
  endtask

  task automatic test_reset_abort();
    longint y; int lat; int seen;
    do_reset();
    wr(0, 8192);
    x_in = N'(5000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_ov_in_reset got %b want 0", out_valid); end
    reset = 1'b0;
    #1;
    model_reset();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    vectors++; if (y_out !== '0) begin miscompares++; $display("FAIL abort_y_out got %0d want 0", y_out); end
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL abort_pulses got %0d want 0", seen); end
    send(1000, y, lat);
    vectors++; if (y != 1000) begin miscompares++; $display("FAIL abort_coef_restored got %0d want 1000", y); end
  endtask

  // in_valid held high with a fresh sample every cycle: only samples seen
  // while idle are taken, one every 11 cycles, each answered 10 edges later
  task automatic test_back_to_back();
    longint xs [33];
    longint ex;
    bit     exp_ov;
    do_reset();
    for (int i = 0; i < NCOEF; i++) wr(i, longint'($urandom_range(0, 32767)) - 16384);
    in_valid = 1'b1;
    for (int c = 0; c < 33; c++) begin
      xs[c] = longint'($urandom_range(0, 16777215)) - 8388608;
      x_in = N'(xs[c]);
      tick();
      exp_ov = (c % 11 == 10);
      vectors++; if (out_valid !== exp_ov) begin miscompares++; $display("FAIL b2b_ov cycle %0d got %b want %b", c, out_valid, exp_ov); end
      vectors++; if (in_ready !== exp_ov) begin miscompares++; $display("FAIL b2b_ready cycle %0d got %b want %b", c, in_ready, exp_ov); end
      if (exp_ov) begin
        ex = model_step(xs[c-10]);
        vectors++; if (longint'(y_out) != ex) begin miscompares++; $display("FAIL b2b_y cycle %0d got %0d want %0d", c, y_out, ex); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    longint y, ex, x; int lat;
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int i = 0; i < NCOEF; i++) begin
        if (round == 0) wr(i, longint'($urandom_range(0, 32767)) - 16384);
        else            wr(i, longint'($urandom_range(0, 16777215)) - 8388608);
      end
      for (int k = 0; k < 20; k++) begin
        if ($urandom_range(0, 5) == 0) clr();
        x = longint'($urandom_range(0, 16777215)) - 8388608;
        ex = model_step(x);
        send(x, y, lat);
        vectors++; if (lat != 10) begin miscompares++; $display("FAIL rand_latency r%0d k%0d got %0d want 10", round, k, lat); end
        vectors++; if (y != ex) begin miscompares++; $display("FAIL rand_y r%0d k%0d x=%0d got %0d want %0d", round, k, x, y, ex); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0; clr_state = 1'b0;
    x_in = '0; coef_addr = '0; coef_data = '0;
    test_reset();
    test_passthrough();
    test_gain();
    test_integrator();
    test_saturation();
    test_coef_err();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
